// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers CoorX/CoorY from HS/VS/BLANK_n and checks line/frame timing.
// Optional VGA_MON_STATS_EN adds frame_cnt/err_cnt statistics outputs.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        HS,
    input  logic        VS,
    input  logic        BLANK_n,
    output logic [10:0] CoorX,
    output logic [9:0]  CoorY,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [10:0] meas_h_total,
    output logic [9:0]  meas_v_total
`ifdef VGA_MON_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [10:0] H_TOTAL_W   = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_W    = 11'(H_SYNC);
    localparam logic [10:0] H_ACTIVE_W  = 11'(H_ACTIVE);
    localparam logic [10:0] H_ACT_M1    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] TIMEOUT_POS = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  V_TOTAL_W   = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_W    = 10'(V_SYNC);
    localparam logic [9:0]  V_ACTIVE_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_M1    = 10'(V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_W      = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        hs_q;
    logic        vs_q;
    logic        bl_q;
    logic        hs_q1;
    logic        vs_q1;
    logic        bl_q1;
    logic        hs_fall;
    logic        vs_fall;
    logic        bl_fall;

    logic [10:0] h_pos;
    logic [10:0] h_len;
    logic [10:0] hs_low;
    logic [10:0] x;
    logic [9:0]  v_pos;
    logic [9:0]  v_len;
    logic [9:0]  vs_low;
    logic [9:0]  y;

    logic        seen_hs;
    logic        frame_bad;
    logic        line_bad;
    logic        frame_good;
    logic        timeout;
    logic        frame_err_next;
    logic [3:0]  good_cnt;
    logic [3:0]  good_cnt_next;
    logic [3:0]  good_inc;

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            bl_q  <= 1'b0;
            hs_q1 <= 1'b0;
            vs_q1 <= 1'b0;
            bl_q1 <= 1'b0;
        end else begin
            hs_q  <= HS;
            vs_q  <= VS;
            bl_q  <= BLANK_n;
            hs_q1 <= hs_q;
            vs_q1 <= vs_q;
            bl_q1 <= bl_q;
        end
    end

    assign hs_fall = hs_q1 & ~hs_q;
    assign vs_fall = vs_q1 & ~vs_q;
    assign bl_fall = bl_q1 & ~bl_q;

    assign h_len = (h_pos == '1) ? h_pos : h_pos + 11'd1;
    assign v_len = (v_pos == '1) ? v_pos : v_pos + 10'd1;

    // h_pos saturates, so equality fires exactly once per loss of HS
    assign timeout = !hs_fall && (h_pos == TIMEOUT_POS);

    assign line_bad = hs_fall && seen_hs && (state != SEARCH) &&
                      !((h_len == H_TOTAL_W) && (hs_low == H_SYNC_W) &&
                        ((x == '0) || (x == H_ACTIVE_W)));

    // The line closing at this vs_fall still belongs to the frame being judged
    assign frame_good = !frame_bad && !line_bad &&
                        (v_len == V_TOTAL_W) && (vs_low == V_SYNC_W) && (y == V_ACTIVE_W);

    assign good_inc = good_cnt + 4'd1;

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            h_pos        <= '0;
            hs_low       <= '0;
            x            <= '0;
            v_pos        <= '0;
            vs_low       <= '0;
            y            <= '0;
            meas_h_total <= '0;
            meas_v_total <= '0;
        end else begin
            if (hs_fall) begin
                h_pos        <= '0;
                hs_low       <= 11'd1;
                x            <= '0;
                meas_h_total <= h_len;
            end else begin
                if (h_pos != '1) h_pos <= h_pos + 11'd1;
                if (!hs_q && hs_low != '1) hs_low <= hs_low + 11'd1;
                if (bl_q && x != '1) x <= x + 11'd1;
            end

            if (vs_fall) begin
                v_pos        <= '0;
                vs_low       <= {9'd0, hs_fall};
                y            <= '0;
                meas_v_total <= v_len;
            end else begin
                if (hs_fall && v_pos != '1) v_pos <= v_pos + 10'd1;
                if (hs_fall && !vs_q && vs_low != '1) vs_low <= vs_low + 10'd1;
                if (bl_fall && y != '1) y <= y + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            seen_hs   <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            // Leaving SEARCH on a combined HS/VS edge arms checking of the line it starts
            if (state == SEARCH && !vs_fall) seen_hs <= 1'b0;
            else if (hs_fall)                seen_hs <= 1'b1;

            if (vs_fall || state == SEARCH) frame_bad <= 1'b0;
            else if (line_bad)              frame_bad <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        good_cnt_next  = good_cnt;
        frame_err_next = 1'b0;
        if (timeout) begin
            state_next    = SEARCH;
            good_cnt_next = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state_next    = MEASURE;
                        good_cnt_next = '0;
                    end
                end
                MEASURE: begin
                    if (vs_fall) begin
                        if (frame_good) begin
                            if (good_inc >= LOCK_W) begin
                                state_next    = LOCKED;
                                good_cnt_next = '0;
                            end else begin
                                good_cnt_next = good_inc;
                            end
                        end else begin
                            good_cnt_next  = '0;
                            frame_err_next = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (vs_fall && !frame_good) begin
                        state_next     = MEASURE;
                        good_cnt_next  = '0;
                        frame_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next    = SEARCH;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            CoorX     <= H_ACTIVE_W;
            CoorY     <= V_ACTIVE_W;
        end else begin
            state     <= state_next;
            good_cnt  <= good_cnt_next;
            locked    <= (state == LOCKED) && !timeout;
            line_err  <= line_bad;
            frame_err <= frame_err_next;

            if (state == SEARCH || timeout || !bl_q) begin
                CoorX <= H_ACTIVE_W;
                CoorY <= V_ACTIVE_W;
            end else begin
                CoorX <= (x > H_ACT_M1) ? H_ACT_M1 : x;
                CoorY <= (y > V_ACT_M1) ? V_ACT_M1 : y;
            end
        end
    end

`ifdef VGA_MON_STATS_EN
    logic frame_checked;

    assign frame_checked = vs_fall && !timeout && (state != SEARCH);

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_checked && frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
            if (frame_err_next && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a reduced 40x12 raster (24x6 active).
module tb_vga_sync_monitor;

    localparam int HT  = 40;
    localparam int HSW = 6;
    localparam int HA  = 24;
    localparam int HAS = 10;
    localparam int VT  = 12;
    localparam int VSW = 2;
    localparam int VA  = 6;
    localparam int VAS = 3;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        HS;
    logic        VS;
    logic        BLANK_n;
    logic [10:0] CoorX;
    logic [9:0]  CoorY;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic [10:0] meas_h_total;
    logic [9:0]  meas_v_total;
`ifdef VGA_MON_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HSW), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VSW), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .HS(HS), .VS(VS), .BLANK_n(BLANK_n),
        .CoorX(CoorX), .CoorY(CoorY), .locked(locked),
        .line_err(line_err), .frame_err(frame_err),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
`ifdef VGA_MON_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct { int due; int x; int y; } coord_t;
    typedef struct { int due; logic le; logic fe; int mh; logic drop; } evt_t;

    coord_t cq[$];
    evt_t   eq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int rst_due  = -1;
    int drop_due = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_CoorX"}, CoorX, HA);
        check({tag, "_CoorY"}, CoorY, VA);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_line_err"}, line_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_meas_h"}, meas_h_total, 0);
        check({tag, "_meas_v"}, meas_v_total, 0);
`ifdef VGA_MON_STATS_EN
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    // Monitor: pops expected coordinates/events as their output cycle arrives
    always @(negedge vga_clk) begin
        coord_t c;
        evt_t   e;
        if (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            check("CoorX", CoorX, c.x);
            check("CoorY", CoorY, c.y);
        end
        if (line_err || frame_err || (eq.size() > 0 && eq[0].due <= cyc)) begin
            if (eq.size() == 0) begin
                check("unexpected_err_pulse", {line_err, frame_err}, 0);
            end else begin
                e = eq.pop_front();
                check("err_pulse_cycle", cyc, e.due);
                check("line_err", line_err, e.le);
                check("frame_err", frame_err, e.fe);
                if (e.mh >= 0) check("meas_h_total_at_err", meas_h_total, e.mh);
                if (e.drop) begin
                    check("locked_at_frame_err", locked, 1);
                    drop_due = cyc + 1;
                end
            end
        end
        if (drop_due == cyc) check("locked_drop", locked, 0);
        if (rst_due == cyc) check_reset_values("midreset");
    end

    task automatic drive_frame(input int long_line, input int vs_lines, input bit prev_bad,
                               input bit prev_locked, input bit chk, input int rst_line);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == long_line) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic act;
                act = (l >= VAS) && (l < VAS + VA) && (h >= HAS) && (h < HAS + HA);
                @(posedge vga_clk);
                #1;
                HS      = (h >= HSW);
                VS      = (l >= vs_lines);
                BLANK_n = act;
                reset   = !(l == rst_line && h == 20);
                if (!reset) rst_due = cyc + 1;
                if (l == 0 && h == 0 && prev_bad)
                    eq.push_back('{cyc + 2, 1'b0, 1'b1, -1, prev_locked});
                if (long_line >= 0 && l == long_line + 1 && h == 0)
                    eq.push_back('{cyc + 2, 1'b1, 1'b0, HT + 1, 1'b0});
                if (chk)
                    cq.push_back('{cyc + 2, act ? h - HAS : HA, act ? l - VAS : VA});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clk);
            #1;
            HS = 1'b1; VS = 1'b1; BLANK_n = 1'b0; reset = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0; HS = 1'b1; VS = 1'b1; BLANK_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check_reset_values("reset");
        idle(3);

        drive_frame(-1, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        check("locked_before_3rd_vsync", locked, 0);
        drive_frame(-1, VSW, 0, 0, 1, -1);
        check("locked_nominal", locked, 1);
        check("meas_h_nominal", meas_h_total, HT);
        check("meas_v_nominal", meas_v_total, VT);

        drive_frame(4, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 1, 1, 0, -1);
        drive_frame(-1, VSW, 0, 0, 1, -1);
        check("locked_before_relock", locked, 0);

        drive_frame(-1, 3, 0, 0, 0, -1);
        check("locked_relocked", locked, 1);
        drive_frame(-1, VSW, 1, 1, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        check("locked_after_one_good", locked, 0);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        check("locked_after_vs_fault", locked, 1);

        idle(30);
        check("locked_before_timeout", locked, 1);
        idle(60);
        check("locked_after_timeout", locked, 0);
        check("CoorX_after_timeout", CoorX, HA);
        check("CoorY_after_timeout", CoorY, VA);

        drive_frame(-1, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, 6);
        check("locked_after_midreset", locked, 0);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        drive_frame(-1, VSW, 0, 0, 0, -1);
        check("locked_final", locked, 1);
        check("meas_h_final", meas_h_total, HT);
        check("meas_v_final", meas_v_total, VT);
`ifdef VGA_MON_STATS_EN
        check("frame_cnt_final", frame_cnt, 2);
        check("err_cnt_final", err_cnt, 0);
`endif
        idle(5);
        check("coord_queue_drained", cq.size(), 0);
        check("event_queue_drained", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
